// File: rtl/tile_map_arbiter.sv
// Tile-map RAM owner. Clears the map after reset, then shares one
// single-port synchronous-read RAM between the VGA pixel stream (which always
// wins) and a valid/ready game-core port. The pixel colouriser gets a tile ID
// exactly one cycle after each coordinate.
//
// Core handshake: a request transfers on a rising clock edge where
// TMA_CoreValid=1 and TMA_CoreReady=1. While TMA_CoreValid=1 and
// TMA_CoreReady=0 the core keeps its request fields stable. TMA_CoreReady is
// combinational, so it may be high while no request is pending.
module tile_map_arbiter #(
    parameter int MAP_W      = 20,
    parameter int MAP_H      = 15,
    parameter int TILE_SHIFT = 5,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 4
) (
    input  logic              TMA_clk,
    input  logic              TMA_rst,
    input  logic [9:0]        TMA_DispX,
    input  logic [9:0]        TMA_DispY,
    output logic [DATA_W-1:0] TMA_PixTile,
    output logic              TMA_PixValid,
    input  logic              TMA_CoreValid,
    input  logic              TMA_CoreWe,
    input  logic [ADDR_W-1:0] TMA_CoreAddr,
    input  logic [DATA_W-1:0] TMA_CoreWData,
    output logic              TMA_CoreReady,
    output logic              TMA_CoreRValid,
    output logic [DATA_W-1:0] TMA_CoreRData,
    output logic              TMA_InitDone
);
    localparam int MAP_N = MAP_W * MAP_H;
    localparam logic [ADDR_W-1:0] MAP_N_A  = ADDR_W'(MAP_N);
    localparam logic [ADDR_W-1:0] MAP_LAST = ADDR_W'(MAP_N - 1);

    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic              last_valid_q;
    logic              init_done_q;
    logic              pix_valid_q;
    logic              disp_rd_q;    // RAM output holds a display read
    logic              core_rd_q;    // RAM output holds a core read
    logic              core_oor_q;   // that core read was out of range
    logic [DATA_W-1:0] held_q;       // tile of the current display tile span
    logic [DATA_W-1:0] core_rdata_q; // last core read result, held
    logic [DATA_W-1:0] ram_rdata_q;
    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    logic [9:0]        x_m1, y_m1, col, row;
    logic [ADDR_W-1:0] disp_addr;
    logic              run, disp_req, disp_need;
    logic              core_ready, core_acc, core_in_range;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    // Pixel coordinates are 1-based; convert to tile column/row and linear address.
    assign x_m1      = TMA_DispX - 10'd1;
    assign y_m1      = TMA_DispY - 10'd1;
    assign col       = x_m1 >> TILE_SHIFT;
    assign row       = y_m1 >> TILE_SHIFT;
    assign disp_addr = ADDR_W'(row) * ADDR_W'(MAP_W) + ADDR_W'(col);

    assign run           = (state_q == S_RUN);
    assign disp_req      = (TMA_DispX != 10'd0);
    assign disp_need     = run && disp_req && (!last_valid_q || (disp_addr != last_addr_q));
    assign core_ready    = run && !TMA_rst && !disp_need;
    assign core_acc      = TMA_CoreValid && core_ready;
    assign core_in_range = (TMA_CoreAddr < MAP_N_A);

    assign TMA_CoreReady  = core_ready;
    assign TMA_PixValid   = pix_valid_q;
    assign TMA_PixTile    = !pix_valid_q ? '0 : (disp_rd_q ? ram_rdata_q : held_q);
    assign TMA_CoreRValid = core_rd_q;
    assign TMA_CoreRData  = core_rd_q ? (core_oor_q ? '0 : ram_rdata_q) : core_rdata_q;
    assign TMA_InitDone   = init_done_q;

    // RAM port owner: clear sweep, else display, else accepted core request.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = disp_addr;
        ram_wdata = '0;
        if (!run) begin
            ram_we   = !TMA_rst;
            ram_addr = clr_cnt_q;
        end else if (disp_need) begin
            ram_addr = disp_addr;
        end else if (core_acc) begin
            ram_addr  = TMA_CoreAddr;
            ram_we    = TMA_CoreWe && core_in_range;
            ram_wdata = TMA_CoreWData;
        end
    end

    // Single-port RAM with synchronous read.
    always_ff @(posedge TMA_clk) begin
        if (ram_we) begin
            mem_q[ram_addr] <= ram_wdata;
        end
        ram_rdata_q <= mem_q[ram_addr];
    end

    // Control FSM, display tracking and registered outputs.
    always_ff @(posedge TMA_clk) begin
        if (TMA_rst) begin
            state_q      <= S_CLEAR;
            clr_cnt_q    <= '0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
            pix_valid_q  <= 1'b0;
            disp_rd_q    <= 1'b0;
            core_rd_q    <= 1'b0;
            core_oor_q   <= 1'b0;
            held_q       <= '0;
            core_rdata_q <= '0;
        end else begin
            pix_valid_q <= disp_req;
            disp_rd_q   <= disp_need;
            core_rd_q   <= core_acc && !TMA_CoreWe;
            core_oor_q  <= !core_in_range;
            if (core_rd_q) begin
                core_rdata_q <= core_oor_q ? '0 : ram_rdata_q;
            end
            if (disp_rd_q) begin
                held_q <= ram_rdata_q;
            end
            // Write-through keeps the held tile coherent with the RAM; it is
            // newer than any capture landing on the same edge.
            if (core_acc && TMA_CoreWe && last_valid_q && (TMA_CoreAddr == last_addr_q)) begin
                held_q <= TMA_CoreWData;
            end
            case (state_q)
                S_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == MAP_LAST) begin
                        state_q     <= S_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!disp_req) begin
                        last_valid_q <= 1'b0;
                    end else if (disp_need) begin
                        last_valid_q <= 1'b1;
                        last_addr_q  <= disp_addr;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_map_arbiter.sv
// Bench for tile_map_arbiter: staged stimulus, a map-level reference model
// and a queue of expected per-cycle outputs checked by a separate monitor.
module tb_tile_map_arbiter;
    localparam int W = 11; // {pix_valid, tile[3:0], rvalid, rdata[3:0], init_done}

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] disp_x, disp_y;
    logic [3:0] pix_tile;
    logic       pix_valid;
    logic       core_valid, core_we;
    logic [8:0] core_addr;
    logic [3:0] core_wdata;
    logic       core_ready, core_rvalid;
    logic [3:0] core_rdata;
    logic       init_done;

    // Staged inputs: applied just after the next rising edge.
    logic       s_rst = 1'b1;
    int         s_x = 0, s_y = 0;
    logic       s_cv = 1'b0, s_we = 1'b0;
    int         s_addr = 0, s_wdata = 0;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic mon_en = 1'b1;

    // Reference model state: map contents and display tile tracking.
    int   model_mem [0:299];
    int   clr_k = 0;
    logic have_last = 1'b0;
    int   last_tile_addr = 0;

    tile_map_arbiter dut (
        .TMA_clk(clk), .TMA_rst(rst),
        .TMA_DispX(disp_x), .TMA_DispY(disp_y),
        .TMA_PixTile(pix_tile), .TMA_PixValid(pix_valid),
        .TMA_CoreValid(core_valid), .TMA_CoreWe(core_we),
        .TMA_CoreAddr(core_addr), .TMA_CoreWData(core_wdata),
        .TMA_CoreReady(core_ready), .TMA_CoreRValid(core_rvalid),
        .TMA_CoreRData(core_rdata), .TMA_InitDone(init_done)
    );

    always #5 clk = ~clk;

    initial begin
        rst = 1'b1; disp_x = '0; disp_y = '0;
        core_valid = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        for (int i = 0; i < 300; i++) model_mem[i] = 0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply staged inputs, check ready, push expected outputs.
    task automatic cycle(output logic acc, output logic rdy);
        logic run, dreq, need, ready_exp, rv, pv, init;
        int daddr, rd, tile;
        @(posedge clk);
        #1;
        rst = s_rst; disp_x = 10'(s_x); disp_y = 10'(s_y);
        core_valid = s_cv; core_we = s_we; core_addr = 9'(s_addr); core_wdata = 4'(s_wdata);
        #5;
        rdy = core_ready;
        acc = 1'b0;
        if (s_rst) begin
            for (int i = 0; i < 300; i++) model_mem[i] = 0;
            clr_k = 0;
            have_last = 1'b0;
            check("ready_in_reset", int'(core_ready), 0);
            exp_q.push_back('0);
        end else begin
            run  = (clr_k >= 300);
            dreq = (s_x != 0);
            daddr = dreq ? ((s_y - 1) / 32) * 20 + (s_x - 1) / 32 : 0;
            need = run && dreq && (!have_last || daddr != last_tile_addr);
            ready_exp = run && !need;
            check("core_ready", int'(core_ready), int'(ready_exp));
            acc = s_cv && ready_exp;
            rv = 1'b0; rd = 0;
            if (acc && !s_we) begin
                rv = 1'b1;
                rd = (s_addr < 300) ? model_mem[s_addr] : 0;
            end
            if (acc && s_we && s_addr < 300) model_mem[s_addr] = s_wdata;
            pv = dreq;
            tile = (run && dreq) ? model_mem[daddr] : 0;
            if (run) begin
                if (dreq) begin
                    have_last = 1'b1;
                    last_tile_addr = daddr;
                end else begin
                    have_last = 1'b0;
                end
            end
            init = (clr_k >= 299);
            if (clr_k < 1000) clr_k++;
            exp_q.push_back({pv, 4'(tile), rv, 4'(rd), init});
        end
    endtask

    // Monitor: compares the outputs of each cycle against the queued expectation.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pix_valid", int'(pix_valid), int'(e[10]));
            check("pix_tile", int'(pix_tile), int'(e[9:6]));
            check("core_rvalid", int'(core_rvalid), int'(e[5]));
            if (e[5]) check("core_rdata", int'(core_rdata), int'(e[4:1]));
            check("init_done", int'(init_done), int'(e[0]));
        end
    end

    task automatic core_op(input logic we, input int addr, input int data);
        logic acc, rdy;
        acc = 1'b0;
        s_cv = 1'b1; s_we = we; s_addr = addr; s_wdata = data;
        for (int n = 0; n < 50 && !acc; n++) cycle(acc, rdy);
        s_cv = 1'b0;
        if (!acc) check("core_op_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic acc, rdy;
        for (int i = 0; i < n; i++) cycle(acc, rdy);
    endtask

    initial begin
        logic acc, rdy;
        int low_cnt, xs, len;

        // Reset for two cycles, then the full clear with random core requests.
        s_rst = 1'b1;
        idle(2);
        s_rst = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            s_cv = 1'($urandom_range(0, 1)); s_we = 1'b0; s_addr = $urandom_range(0, 299);
            s_x = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 640);
            s_y = $urandom_range(1, 480);
            cycle(acc, rdy);
            if (rdy) low_cnt++;
        end
        check("ready_during_clear_count", low_cnt, 0);
        s_cv = 1'b0; s_x = 0;
        idle(2);

        // Read of a cleared location.
        core_op(1'b0, 137, 0);
        idle(1);

        // Tile 5 at row 1 col 1, scanned across X=32..64 on Y=33.
        core_op(1'b1, 21, 5);
        s_y = 33;
        for (int x = 32; x <= 64; x++) begin
            s_x = x;
            cycle(acc, rdy);
        end
        s_x = 0;
        idle(1);

        // Core read held valid across a full line: ready drops once per tile.
        s_y = $urandom_range(1, 480);
        s_cv = 1'b1; s_we = 1'b0; s_addr = $urandom_range(0, 299);
        low_cnt = 0;
        for (int x = 1; x <= 640; x++) begin
            s_x = x;
            cycle(acc, rdy);
            if (!rdy) low_cnt++;
            if (acc) s_addr = $urandom_range(0, 299);
        end
        check("line_ready_low_count", low_cnt, 20);
        s_cv = 1'b0; s_x = 0;
        idle(1);

        // Write-through while the display sits on address 0.
        s_y = 1;
        for (int x = 1; x <= 31; x++) begin
            s_x = x;
            s_cv = (x == 10); s_we = 1'b1; s_addr = 0; s_wdata = 9;
            cycle(acc, rdy);
            if (x == 10) check("write_through_accept", int'(acc), 1);
        end
        s_cv = 1'b0; s_x = 0;
        idle(1);

        // Out-of-range accesses and the last valid address.
        core_op(1'b1, 299, 3);
        core_op(1'b1, 300, 7);
        core_op(1'b0, 300, 0);
        core_op(1'b0, 299, 0);
        idle(1);

        // Random display lines with random core traffic.
        s_cv = 1'b0;
        for (int l = 0; l < 40; l++) begin
            s_y = $urandom_range(1, 480);
            xs = $urandom_range(1, 600);
            len = $urandom_range(1, 640 - xs);
            for (int x = xs; x < xs + len && x <= 640; x++) begin
                s_x = x;
                if (!s_cv) begin
                    s_cv = 1'($urandom_range(0, 1)); s_we = 1'($urandom_range(0, 1));
                    s_addr = $urandom_range(0, 310); s_wdata = $urandom_range(0, 15);
                end
                cycle(acc, rdy);
                if (acc) s_cv = 1'b0;
            end
            s_x = 0;
            s_cv = 1'b0;
            idle($urandom_range(0, 3));
        end

        // Reset while a core read is presented in RUN; map is cleared again.
        core_op(1'b1, 21, 5);
        s_cv = 1'b1; s_we = 1'b0; s_addr = 21; s_x = 0;
        s_rst = 1'b1;
        cycle(acc, rdy);
        s_rst = 1'b0; s_cv = 1'b0;
        idle(302);
        core_op(1'b0, 21, 0);
        idle(3);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
